// File: rtl/mult_step_scheduler_pkg.sv
// Shared definitions for the multiplier step scheduler: state encoding and default sizing.
package mult_step_scheduler_pkg;

    localparam int DEFAULT_DIV   = 500000;
    localparam int DEFAULT_STEPS = 8;
    localparam int DEFAULT_SW    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_STEP   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/mult_step_scheduler_if.sv
// Board-side controls and multiplier-side pulses of the step scheduler, plus debug visibility.
interface mult_step_scheduler_if import mult_step_scheduler_pkg::*;
#(
    parameter int SW = DEFAULT_SW,
    parameter int CW = 19
);
    // Every control output is a single-cycle pulse, with no back-pressure: the
    // multiplier must act on load/step_en in the cycle they are high. start and
    // step_btn are single-cycle requests that are dropped if the FSM cannot take them.
    logic          start;
    logic          abort;
    logic          mode_run;
    logic          step_btn;
    logic          load;
    logic          step_en;
    logic          done;
    logic          busy;
    logic [SW-1:0] step_idx;
    logic          tick;
    state_t        state;
    logic [CW-1:0] prescale_count;

    modport master (
        output start, abort, mode_run, step_btn,
        input  load, step_en, done, busy, step_idx, tick, state, prescale_count
    );

    modport slave (
        input  start, abort, mode_run, step_btn,
        output load, step_en, done, busy, step_idx, tick, state, prescale_count
    );

endinterface

// File: rtl/mult_step_scheduler_step_prescaler.sv
// Free-running wrap counter that produces the RUN-mode step tick once every DIV cycles.
module step_prescaler #(
    parameter int DIV = 500000,
    parameter int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tick
);

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == CW'(DIV - 1));

    // clr realigns the phase so the first step lands exactly DIV cycles after load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign tick  = w_wrap;

endmodule

// File: rtl/mult_step_scheduler.sv
// Sequences the serial multiplier: one load, STEPS step enables paced by tick or button, then done.
module mult_step_scheduler
    import mult_step_scheduler_pkg::*;
#(
    parameter int DIV   = DEFAULT_DIV,
    parameter int STEPS = DEFAULT_STEPS,
    parameter int SW    = DEFAULT_SW
) (
    input  logic                   clk,
    input  logic                   rst,
    mult_step_scheduler_if.slave   bus
);

    localparam int CW = $clog2(DIV);

    state_t        r_state;
    logic [SW-1:0] r_step_idx;
    logic          w_tick;
    logic          w_accept;
    logic          w_advance;
    logic [CW-1:0] w_count;

    assign w_accept  = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_advance = bus.mode_run ? w_tick : bus.step_btn;

    step_prescaler #(
        .DIV (DIV),
        .CW  (CW)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .count (w_count),
        .tick  (w_tick)
    );

    // Abort outranks every transition, including the FINISH -> IDLE return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step_idx <= '0;
        end else if (r_state != S_IDLE && bus.abort) begin
            r_state    <= S_IDLE;
            r_step_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_LOAD;
                        r_step_idx <= '0;
                    end
                end
                S_LOAD: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_advance) r_state <= S_STEP;
                end
                S_STEP: begin
                    r_step_idx <= r_step_idx + 1'b1;
                    if (r_step_idx == SW'(STEPS - 1)) r_state <= S_FINISH;
                    else                              r_state <= S_WAIT;
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.load           = (r_state == S_LOAD);
    assign bus.step_en        = (r_state == S_STEP);
    assign bus.done           = (r_state == S_FINISH);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.step_idx       = r_step_idx;
    assign bus.tick           = w_tick;
    assign bus.state          = r_state;
    assign bus.prescale_count = w_count;

endmodule

// File: tb/tb_mult_step_scheduler.sv
// Directed scenarios for the step scheduler; pulse events are checked against an expected-event queue.
module tb_mult_step_scheduler;
    import mult_step_scheduler_pkg::*;

    localparam int DIV   = 4;
    localparam int STEPS = 3;
    localparam int SW    = 4;
    localparam int CW    = $clog2(DIV);
    localparam int W     = 18;

    localparam int EV_LOAD = 1;
    localparam int EV_STEP = 2;
    localparam int EV_DONE = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mult_step_scheduler_if #(.SW(SW), .CW(CW)) ifc ();

    mult_step_scheduler #(
        .DIV   (DIV),
        .STEPS (STEPS),
        .SW    (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_ev(int kind, int c);
        exp_q.push_back({2'(kind), 16'(c)});
    endfunction

    function automatic void match_ev(int kind);
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {2'(kind), 16'(cyc)};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected nothing", kind, cyc);
        end else begin
            want = exp_q.pop_front();
            if (want != got) begin
                errors++;
                $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         kind, cyc, int'(want[17:16]), int'(want[15:0]));
            end
        end
    endfunction

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.load)    match_ev(EV_LOAD);
            if (ifc.step_en) match_ev(EV_STEP);
            if (ifc.done)    match_ev(EV_DONE);
        end
    end

    // driver tasks
    task automatic idle_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_case(input bit start_mid);
        int t0;
        t0 = cyc;
        ifc.mode_run = 1'b1;
        expect_ev(EV_LOAD, t0 + 1);
        expect_ev(EV_STEP, t0 + 5);
        expect_ev(EV_STEP, t0 + 9);
        expect_ev(EV_STEP, t0 + 13);
        expect_ev(EV_DONE, t0 + 14);
        ifc.start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ifc.start    = start_mid && (k == 6);
            ifc.step_btn = (k == 3);
            check("run_busy", int'(ifc.busy), int'(k <= 14));
            check("run_tick", int'(ifc.tick), int'(k % 4 == 0));
            if (k == 14 || k == 16) check("run_step_idx", int'(ifc.step_idx), STEPS);
        end
        ifc.step_btn = 1'b0;
    endtask

    initial begin
        int t0;
        rst          = 1'b1;
        ifc.start    = 1'b0;
        ifc.abort    = 1'b0;
        ifc.mode_run = 1'b1;
        ifc.step_btn = 1'b0;
        idle_cycles(3);
        check("reset_load", int'(ifc.load), 0);
        check("reset_step_en", int'(ifc.step_en), 0);
        check("reset_done", int'(ifc.done), 0);
        check("reset_busy", int'(ifc.busy), 0);
        check("reset_tick", int'(ifc.tick), 0);
        check("reset_step_idx", int'(ifc.step_idx), 0);
        check("reset_state", int'(ifc.state), int'(S_IDLE));
        check("reset_count", int'(ifc.prescale_count), 0);
        rst = 1'b0;
        idle_cycles(3);

        // RUN timing, then the same with a start while busy
        run_case(1'b0);
        idle_cycles(2);
        run_case(1'b1);
        idle_cycles(2);

        // abort mid-operation
        t0 = cyc;
        ifc.mode_run = 1'b1;
        expect_ev(EV_LOAD, t0 + 1);
        expect_ev(EV_STEP, t0 + 5);
        ifc.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ifc.start = 1'b0;
            ifc.abort = (k == 7);
            if (k == 7) check("abort_idx_before", int'(ifc.step_idx), 1);
            if (k == 8) begin
                check("abort_busy", int'(ifc.busy), 0);
                check("abort_state", int'(ifc.state), int'(S_IDLE));
                check("abort_step_idx", int'(ifc.step_idx), 0);
            end
        end

        // start together with abort in IDLE
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        check("start_abort_busy", int'(ifc.busy), 0);
        check("start_abort_state", int'(ifc.state), int'(S_IDLE));
        idle_cycles(3);
        check("start_abort_still_idle", int'(ifc.busy), 0);

        // SINGLE-STEP mode
        t0 = cyc;
        ifc.mode_run = 1'b0;
        expect_ev(EV_LOAD, t0 + 1);
        expect_ev(EV_STEP, t0 + 11);
        expect_ev(EV_STEP, t0 + 31);
        expect_ev(EV_STEP, t0 + 33);
        expect_ev(EV_DONE, t0 + 34);
        ifc.start = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            ifc.start    = 1'b0;
            ifc.step_btn = (k == 1 || k == 10 || k == 30 || k == 31 || k == 32);
            if (k == 20) check("single_wait_state", int'(ifc.state), int'(S_WAIT));
            if (k == 34) check("single_step_idx", int'(ifc.step_idx), STEPS);
            if (k == 36) check("single_busy_end", int'(ifc.busy), 0);
        end
        ifc.step_btn = 1'b0;
        idle_cycles(2);

        // RUN -> SINGLE-STEP switch after the first step
        t0 = cyc;
        ifc.mode_run = 1'b1;
        expect_ev(EV_LOAD, t0 + 1);
        expect_ev(EV_STEP, t0 + 5);
        expect_ev(EV_STEP, t0 + 16);
        expect_ev(EV_STEP, t0 + 21);
        expect_ev(EV_DONE, t0 + 22);
        ifc.start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            ifc.start    = 1'b0;
            ifc.mode_run = (k < 6);
            ifc.step_btn = (k == 15 || k == 20);
            if (k == 12) check("switch_idx_hold", int'(ifc.step_idx), 1);
        end
        ifc.step_btn = 1'b0;
        ifc.mode_run = 1'b1;
        idle_cycles(2);

        // asynchronous reset mid-operation
        t0 = cyc;
        expect_ev(EV_LOAD, t0 + 1);
        expect_ev(EV_STEP, t0 + 5);
        ifc.start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ifc.start = 1'b0;
            if (k == 7) begin
                check("rst_idx_before", int'(ifc.step_idx), 1);
                rst = 1'b1;
                #1;
                check("rst_async_busy", int'(ifc.busy), 0);
                check("rst_async_state", int'(ifc.state), int'(S_IDLE));
                check("rst_async_step_idx", int'(ifc.step_idx), 0);
                check("rst_async_outputs", int'({ifc.load, ifc.step_en, ifc.done, ifc.tick}), 0);
            end
            if (k == 8) check("rst_tick_held", int'(ifc.tick), 0);
            if (k == 9) rst = 1'b0;
            if (k >= 10) check("rst_busy_after", int'(ifc.busy), 0);
        end

        @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
